// File: rtl/stoch_grad_gate_if.sv
// Handshake bundle for stoch_grad_gate.
//   slave  : the gate itself (takes flip masks, produces gated masks)
//   master : upstream producer / downstream consumer side
// Signals:
//   in_valid_in, in_ready_out, flip_weight_in[W_SIZE], rate_in[LFSR_W]
//   out_valid_out, out_ready_in, flip_weight_out[W_SIZE], flip_count_out[CNT_W]
interface stoch_grad_gate_if #(
   parameter int W_SIZE = 256,
   parameter int LFSR_W = 13,
   parameter int CNT_W  = $clog2(W_SIZE + 1)
);
   logic              in_valid_in;
   logic              in_ready_out;
   logic [W_SIZE-1:0] flip_weight_in;
   logic [LFSR_W-1:0] rate_in;
   logic              out_valid_out;
   logic              out_ready_in;
   logic [W_SIZE-1:0] flip_weight_out;
   logic [CNT_W-1:0]  flip_count_out;

   modport master (
      output in_valid_in, flip_weight_in, rate_in, out_ready_in,
      input  in_ready_out, out_valid_out, flip_weight_out, flip_count_out
   );

   modport slave (
      input  in_valid_in, flip_weight_in, rate_in, out_ready_in,
      output in_ready_out, out_valid_out, flip_weight_out, flip_count_out
   );
endinterface

// File: rtl/stoch_grad_gate.sv
// stoch_grad_gate: stochastic gate for weight-flip requests.
// Each set bit of the accepted flip mask survives when its lane LFSR value is
// <= the latched rate, i.e. with probability rate/8191. LANES bits are gated per
// cycle; the gated mask and its popcount are returned over the output handshake.
// Ports:
//   clk_in        rising-edge clock
//   rst_in        asynchronous active-low reset
//   bus (slave)   input handshake + mask/rate, output handshake + mask/count
//   seed_valid_in, seed_in   only with STOCH_GRAD_SEED_LOAD_EN defined: reseed
//                            all lanes while idle
// Optional feature macro: STOCH_GRAD_SEED_LOAD_EN
//
// state | meaning
// IDLE  | waiting for a vector, ready high
// RUN   | gating one LANES-wide chunk per cycle
// OUT   | result valid, held until consumed
module stoch_grad_gate #(
   parameter int W_SIZE = 256,
   parameter int LANES  = 16,
   parameter int LFSR_W = 13
) (
   input  logic              clk_in,
   input  logic              rst_in,
`ifdef STOCH_GRAD_SEED_LOAD_EN
   input  logic              seed_valid_in,
   input  logic [LFSR_W-1:0] seed_in,
`endif
   stoch_grad_gate_if.slave  bus
);
   localparam int NCHUNK = W_SIZE / LANES;
   localparam int CNT_W  = $clog2(W_SIZE + 1);
   localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]        r_state;
   logic [CH_W-1:0]   r_chunk;
   logic [W_SIZE-1:0] r_vec;
   logic [LFSR_W-1:0] r_rate;
   logic [W_SIZE-1:0] r_res;
   logic [CNT_W-1:0]  r_cnt;
   logic [LFSR_W-1:0] r_lfsr [LANES];

   logic              w_in_ready;
   logic              w_accept;
   logic [LANES-1:0]  w_slice_in;
   logic [LANES-1:0]  w_slice;
   logic [CNT_W-1:0]  w_slice_cnt;
   logic [LFSR_W-1:0] w_lfsr_nxt [LANES];

   // Lane seed: never zero, spread lanes far apart in the sequence.
   function automatic logic [LFSR_W-1:0] seed_f(input int base, input int lane);
      int v;
      v = 1 + ((base + lane * 1237) % 8191);
      return v[LFSR_W-1:0];
   endfunction

   assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready_in);
   assign w_accept   = bus.in_valid_in && w_in_ready;
   assign w_slice_in = r_vec[r_chunk*LANES +: LANES];

   always_comb begin
      w_slice_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         w_slice[i]    = w_slice_in[i] && (r_lfsr[i] <= r_rate);
         w_slice_cnt   = w_slice_cnt + CNT_W'(w_slice[i]);
         // x^13 + x^4 + x^3 + x + 1
         w_lfsr_nxt[i] = {r_lfsr[i][LFSR_W-2:0],
                          r_lfsr[i][12] ^ r_lfsr[i][3] ^ r_lfsr[i][2] ^ r_lfsr[i][0]};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= S_IDLE;
         r_chunk <= '0;
         r_vec   <= '0;
         r_rate  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         for (int i = 0; i < LANES; i++) r_lfsr[i] <= seed_f(0, i);
      end else if (w_accept) begin
         // Also taken from OUT: the old result is still shown this cycle.
         r_vec   <= bus.flip_weight_in;
         r_rate  <= bus.rate_in;
         r_res   <= '0;
         r_cnt   <= '0;
         r_chunk <= '0;
         r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
         r_res[r_chunk*LANES +: LANES] <= w_slice;
         r_cnt <= r_cnt + w_slice_cnt;
         for (int i = 0; i < LANES; i++) r_lfsr[i] <= w_lfsr_nxt[i];
         if (r_chunk == CH_W'(NCHUNK - 1)) begin
            r_state <= S_OUT;
         end else begin
            r_chunk <= r_chunk + 1'b1;
         end
      end else if (r_state == S_OUT) begin
         if (bus.out_ready_in) r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
`ifdef STOCH_GRAD_SEED_LOAD_EN
         if (seed_valid_in) begin
            for (int i = 0; i < LANES; i++) r_lfsr[i] <= seed_f(int'(seed_in), i);
         end
`endif
      end else begin
         r_state <= S_IDLE;
      end
   end

   assign bus.in_ready_out    = w_in_ready;
   assign bus.out_valid_out   = (r_state == S_OUT);
   assign bus.flip_weight_out = r_res;
   assign bus.flip_count_out  = r_cnt;
endmodule
